// File: rtl/cic_comb_chain.sv
// Comb section of a CIC decimator: N cascaded y[n] = x[n] - x[n-M] stages,
// one register per stage, with the final result truncated to its OW MSBs.
module cic_comb_chain #(
  parameter int W  = 16,
  parameter int N  = 3,
  parameter int M  = 1,
  parameter int OW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_valid,
  input  logic [W-1:0]  i_data,
  output logic [OW-1:0] o_data,
  output logic          o_valid
);

  if (N < 1 || N > 8) begin : g_bad_n
    $fatal(1, "cic_comb_chain: N=%0d outside 1..8", N);
  end
  if (M < 1 || M > 4) begin : g_bad_m
    $fatal(1, "cic_comb_chain: M=%0d outside 1..4", M);
  end
  if (OW < 1 || OW > W) begin : g_bad_ow
    $fatal(1, "cic_comb_chain: OW=%0d must be 1..W", OW);
  end

  // Element k is the input of stage k; element N is the chain output.
  logic [N:0][W-1:0] chain_data;
  logic [N:0]        chain_valid;

  assign chain_data[0]  = i_data;
  assign chain_valid[0] = i_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic [W-1:0] out_reg;
      logic         valid_reg;
      logic [W-1:0] tap_reg [0:M-1];

      // Taps and result only move on accepted samples, so gaps are transparent.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          out_reg   <= '0;
          valid_reg <= 1'b0;
          for (int j = 0; j < M; j++) begin
            tap_reg[j] <= '0;
          end
        end else if (i_ce) begin
          valid_reg <= chain_valid[gi];
          if (chain_valid[gi]) begin
            out_reg    <= chain_data[gi] - tap_reg[M-1];
            tap_reg[0] <= chain_data[gi];
            for (int j = 1; j < M; j++) begin
              tap_reg[j] <= tap_reg[j-1];
            end
          end
        end
      end

      assign chain_data[gi+1]  = out_reg;
      assign chain_valid[gi+1] = valid_reg;
    end
  endgenerate

  assign o_data  = chain_data[N][W-1 -: OW];
  assign o_valid = chain_valid[N];

endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: three parameterisations share one stimulus stream and
// are compared each cycle against a binomial-expansion reference of the comb cascade.
module tb_cic_comb_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] oa, ob;
  logic [7:0]  oc;
  logic        va, vb, vc;

  always #5 clk = ~clk;

  cic_comb_chain #(.W(16), .N(3), .M(1), .OW(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .i_data(din),
    .o_data(oa), .o_valid(va));
  cic_comb_chain #(.W(16), .N(1), .M(1), .OW(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .i_data(din),
    .o_data(ob), .o_valid(vb));
  cic_comb_chain #(.W(16), .N(1), .M(2), .OW(8)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .i_data(din),
    .o_data(oc), .o_valid(vc));

  int ns  [3] = '{3, 1, 1};
  int ms  [3] = '{1, 1, 2};
  int ows [3] = '{16, 16, 8};

  int total = 0;
  int bad   = 0;

  // Reference state: accepted samples since reset, and what each enabled edge saw.
  int hist   [0:4095];
  bit in_v   [0:4095];
  int in_idx [0:4095];
  int hcount, ecount;
  int exp_v [3];
  int exp_d [3];

  // y[n] = sum_k (-1)^k C(N,k) x[n-kM], zero initial conditions, mod 2^16, top OW bits.
  function automatic int ref_out(int idx, int n, int m, int ow);
    longint s = 0;
    longint c = 1;
    for (int k = 0; k <= n; k++) begin
      if (idx - k * m >= 0)
        s += ((k % 2) != 0 ? -c : c) * longint'(hist[idx - k * m]);
      c = c * (n - k) / (k + 1);
    end
    s = s & 64'hFFFF;
    return int'(s >>> (16 - ow));
  endfunction

  task automatic model_clear();
    hcount = 0;
    ecount = 0;
    for (int d = 0; d < 3; d++) begin
      exp_v[d] = 0;
      exp_d[d] = 0;
    end
  endtask

  // A sample accepted on enabled edge e leaves the chain on enabled edge e+N-1.
  task automatic model_edge();
    int src;
    if (rst) begin
      model_clear();
    end else if (ce) begin
      in_v[ecount] = vld;
      if (vld) begin
        hist[hcount]   = int'($signed(din));
        in_idx[ecount] = hcount;
        hcount++;
      end
      ecount++;
      for (int d = 0; d < 3; d++) begin
        src = ecount - ns[d];
        if (src >= 0 && in_v[src]) begin
          exp_v[d] = 1;
          exp_d[d] = ref_out(in_idx[src], ns[d], ms[d], ows[d]);
        end else begin
          exp_v[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("a_valid", int'(va), exp_v[0]);
    chk("a_data",  int'(oa), exp_d[0]);
    chk("b_valid", int'(vb), exp_v[1]);
    chk("b_data",  int'(ob), exp_d[1]);
    chk("c_valid", int'(vc), exp_v[2]);
    chk("c_data",  int'(oc), exp_d[2]);
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic c);
    vld = v;
    din = d;
    ce  = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset is asserted and released away from clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_all();
    cyc(1'b1, 16'd77, 1'b1);
    cyc(1'b1, 16'd77, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int step_exp [6] = '{100, 16'hFF38, 100, 0, 0, 0};
  int gap_exp  [4] = '{100, 16'hFF38, 100, 0};
  int dly_exp  [4] = '{2, 4, 4, 4};
  int dly_in   [4] = '{512, 1024, 1536, 2048};
  int got [$];
  int prev_v;

  initial begin
    model_clear();
    #2 rst = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Step response
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 16'd100, 1'b1);
      chk("step_valid", int'(va), (c >= 2) ? 1 : 0);
      if (c >= 2) chk("step_data", int'(oa), step_exp[c - 2]);
    end

    // Decimator cadence: one sample in five
    do_reset();
    got.delete();
    prev_v = 0;
    for (int c = 0; c < 40; c++) begin
      cyc((c % 5) == 0, 16'd100, 1'b1);
      chk("gap_latency", int'(va), (c >= 2 && ((c - 2) % 5) == 0) ? 1 : 0);
      chk("gap_adjacent", int'(va) & prev_v, 0);
      prev_v = int'(va);
      if (va) got.push_back(int'(oa));
    end
    chk("gap_count", got.size(), 8);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("gap_data", got[i], gap_exp[i]);

    // Modular wrap, no saturation
    do_reset();
    cyc(1'b1, 16'h7FFF, 1'b1);
    chk("wrap_first", int'(ob), 32767);
    cyc(1'b1, 16'h8000, 1'b1);
    chk("wrap_second", int'(ob), 1);

    // M=2 with 8-bit truncated output
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'(dly_in[i]), 1'b1);
      chk("delay_trunc", int'(oc), dly_exp[i]);
    end

    // Clock-enable freeze; valid held high with junk data while frozen
    do_reset();
    cyc(1'b1, 16'd10, 1'b1);
    cyc(1'b1, 16'd20, 1'b1);
    repeat (4) cyc(1'b1, 16'h5555, 1'b0);
    cyc(1'b1, 16'd30, 1'b1);
    repeat (6) cyc(1'b0, 16'd0, 1'b1);

    // Asynchronous reset in the middle of a running step
    do_reset();
    repeat (6) cyc(1'b1, 16'd100, 1'b1);
    #3 rst = 1'b1;
    #1;
    model_clear();
    chk("midrst_valid", int'(va), 0);
    chk("midrst_data", int'(oa), 0);
    cyc(1'b1, 16'd100, 1'b1);
    cyc(1'b1, 16'd100, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cyc(1'b1, 16'd100, 1'b1);
      chk("restart_valid", int'(va), (c >= 2) ? 1 : 0);
      if (c >= 2) chk("restart_data", int'(oa), step_exp[c - 2]);
    end

    // Random valid, enable and data
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int i = 0; i < 200; i++)
        cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
